// File: rtl/cond_flag_unit_pkg.sv
// Shared CPU definitions: condition codes, flag bit positions,
// and the commit-control state encoding.
package cond_flag_unit_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/cond_flag_unit_if.sv
// Execute-stage bundle between the decoder/ALU side
// and the condition/flag unit.
interface cond_flag_unit_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             NoWrite;
  logic             Stall;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic [3:0]       Flags;
  logic             C_Flag;
  logic [CNT_W-1:0] SkipCount;

  modport master (
    output Cond, ALUFlags, FlagW,
    output PCS, RegW, MemW, NoWrite, Stall,
    input  PCSrc, RegWrite, MemWrite, CondEx,
    input  Flags, C_Flag, SkipCount
  );

  modport slave (
    input  Cond, ALUFlags, FlagW,
    input  PCS, RegW, MemW, NoWrite, Stall,
    output PCSrc, RegWrite, MemWrite, CondEx,
    output Flags, C_Flag, SkipCount
  );

endinterface

// File: rtl/cond_flag_unit_check.sv
// ARM condition evaluation against the architectural flags.
// Purely combinational.
module cond_check
  import cond_flag_unit_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b0;
    unique case (cond_e'(Cond))
      EQ: CondEx = z;
      NE: CondEx = !z;
      CS: CondEx = c;
      CC: CondEx = !c;
      MI: CondEx = n;
      PL: CondEx = !n;
      VS: CondEx = v;
      VC: CondEx = !v;
      HI: CondEx = c & !z;
      LS: CondEx = !c | z;
      GE: CondEx = (n == v);
      LT: CondEx = (n != v);
      GT: CondEx = !z & (n == v);
      LE: CondEx = z | (n != v);
      AL: CondEx = 1'b1;
      NV: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Conditional-execution gate: flag register, commit control
// and a saturating count of condition-failed instructions.
module cond_flag_unit
  import cond_flag_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic             CLK,
  input logic             RESET,
  cond_flag_unit_if.slave bus
);

  state_e           state_q, state_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] skip_q, skip_d;
  logic             cond_ex;
  logic             commit;

  cond_check u_check (
    .Cond   (bus.Cond),
    .Flags  (flags_q),
    .CondEx (cond_ex)
  );

  assign commit = !bus.Stall;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= RUN;
      flags_q <= '0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:  if (bus.Stall) state_d = HOLD;
      HOLD: if (!bus.Stall) state_d = RUN;
    endcase
  end

  // Flags only move on a passing commit; failed commits bump the counter.
  always_comb begin
    flags_d = flags_q;
    skip_d  = skip_q;
    if (commit && cond_ex) begin
      if (bus.FlagW[1]) begin
        flags_d[FLAG_N] = bus.ALUFlags[FLAG_N];
        flags_d[FLAG_Z] = bus.ALUFlags[FLAG_Z];
      end
      if (bus.FlagW[0]) begin
        flags_d[FLAG_C] = bus.ALUFlags[FLAG_C];
        flags_d[FLAG_V] = bus.ALUFlags[FLAG_V];
      end
    end else if (commit && (skip_q != '1)) begin
      skip_d = skip_q + CNT_W'(1);
    end
  end

  always_comb begin
    bus.PCSrc    = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemWrite = 1'b0;
    if (commit) begin
      bus.PCSrc    = bus.PCS & cond_ex;
      bus.RegWrite = bus.RegW & cond_ex & !bus.NoWrite;
      bus.MemWrite = bus.MemW & cond_ex;
    end
  end

  assign bus.CondEx    = cond_ex;
  assign bus.Flags     = flags_q;
  assign bus.C_Flag    = flags_q[FLAG_C];
  assign bus.SkipCount = skip_q;

endmodule

// File: doc/cond_flag_unit.md
COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the skipped-instruction counter.
REQ-002 SHALL have port CLK  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-004 SHALL have port Cond  in  4  ARM condition field of the instruction in execute.
REQ-005 SHALL have port ALUFlags  in  4  {N,Z,C,V} produced by the ALU this cycle.
REQ-006 SHALL have port FlagW  in  2  flag write request: bit1 updates N,Z; bit0 updates C,V.
REQ-007 SHALL have port PCS, RegW, MemW, NoWrite  in  1 each  decoder-proposed side effects.
REQ-008 SHALL have port Stall  in  1  multi-cycle unit busy; instruction must not commit.
REQ-009 SHALL have port PCSrc, RegWrite, MemWrite  out  1 each  gated side effects.
REQ-010 SHALL have port CondEx  out  1  condition-passed indicator for the current instruction.
REQ-011 SHALL have port Flags  out  4  architectural {N,Z,C,V} register.
REQ-012 SHALL have port C_Flag  out  1  registered C bit fed to the ALU carry-in path (ADC/SBC/RSC).
REQ-013 SHALL have port SkipCount  out  CNT_W  count of committed condition-failed instructions.

Function
REQ-014 SHALL evaluate CondEx combinationally from the registered Flags, never from ALUFlags.
REQ-015 SHALL decode Cond: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V.
REQ-016 SHALL decode Cond: 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 always 1; 1111 always 0.
REQ-017 SHALL implement a two-state FSM: RUN and HOLD.
REQ-018 SHALL move RUN->HOLD when Stall=1, HOLD->RUN when Stall=0, and stay in RUN while Stall=0.
REQ-019 SHALL commit only in a cycle with Stall=0; the commit cycle is the cycle Stall is low.
REQ-020 SHALL force PCSrc, RegWrite and MemWrite to 0 whenever Stall=1, in either state.
REQ-021 SHALL, in a commit cycle, drive PCSrc=PCS&CondEx, RegWrite=RegW&CondEx&!NoWrite, MemWrite=MemW&CondEx.
REQ-022 SHALL, on a commit edge with CondEx=1, load N,Z from ALUFlags if FlagW[1] and C,V from ALUFlags if FlagW[0]; other bits are held.
REQ-023 SHALL leave Flags unchanged on any edge where Stall=1 or CondEx=0.
REQ-024 SHALL present updated Flags, and therefore C_Flag and CondEx, one cycle after the commit edge; there is no bypass.
REQ-025 SHALL drive C_Flag equal to Flags[1] at all times.
REQ-026 SHALL increment SkipCount on each commit edge with CondEx=0, saturating at all-ones (no wrap).
REQ-027 SHALL keep NoWrite suppressing RegWrite only, so TST/TEQ/CMP/CMN still update flags.

Reset
REQ-028 SHALL, on RESET=1 at a rising edge, set Flags=0000, state=RUN and SkipCount=0.
REQ-029 SHALL give RESET priority over Stall and over a simultaneous commit; reset mid-HOLD returns to RUN with no flag update.
REQ-030 SHALL derive combinational outputs from the reset state in the cycle after reset: C_Flag=0, and Cond=0000 gives CondEx=0.

Structure
REQ-031 SHALL take condition-code encodings (EQ..AL, NV) and flag bit indices (N=3, Z=2, C=1, V=0) from the shared CPU package.
REQ-032 SHALL place condition evaluation in one combinational sub-module, cond_check (Cond, Flags -> CondEx).
REQ-033 SHALL hold the FSM state, flag register and counter in cond_flag_unit itself.

Verification
REQ-034 SHALL cover: after reset, Cond=1110, ALUFlags=0100, FlagW=11, RegW=1 -> RegWrite=1; next cycle Flags=0100; then Cond=0000 -> CondEx=1.
REQ-035 SHALL cover: Flags=0000, Cond=0000, MemW=1, FlagW=11, ALUFlags=1111 -> MemWrite=0; Flags stay 0000; SkipCount goes 0->1.
REQ-036 SHALL cover: Flags=0000, Cond=1110, FlagW=01, ALUFlags=1010 -> Flags=0010 and C_Flag=1 next cycle.
REQ-037 SHALL cover: Stall=1 for 3 cycles with Cond=1110, RegW=1, FlagW=11, ALUFlags=1000 -> RegWrite=0 and Flags unchanged for those cycles; Stall=0 -> RegWrite=1; Flags=1000 next cycle.
REQ-038 SHALL cover: SkipCount preloaded near the limit (CNT_W=4, 15 skips), then 2 more skips -> SkipCount stays 1111.
REQ-039 SHALL cover: RESET asserted in HOLD with FlagW=11 and ALUFlags=1111 -> Flags=0000, state=RUN and SkipCount=0 next cycle.
